reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised multi-port register file for the datapath: DEPTH x DATA_W storage, NUM_RD combinational read ports, two synchronous write ports with fixed priority.
Adds a multi-cycle sweep-clear sequencer so software or control can zero the file without asserting reset, plus an optionally hard-wired zero register.
Sits between decode (addresses) and the ALU/writeback stage.

Parameters:
DATA_W, 8, register width in bits
DEPTH, 8, number of registers (>=2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
wr_en0  in  1  write port 0 enable
wr_addr0  in  ADDR_W  write port 0 address
wr_data0  in  DATA_W  write port 0 data
wr_en1  in  1  write port 1 enable (higher priority)
wr_addr1  in  ADDR_W  write port 1 address
wr_data1  in  DATA_W  write port 1 data
wr_rdy  out  1  writes accepted this cycle (= !clr_busy)
clr_req  in  1  start sweep clear (sampled in IDLE only)
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse when sweep completes

Behaviour:
- Reset (async): all registers = 0; FSM = IDLE; clr_ptr = 0; clr_busy = 0; clr_done = 0; wr_rdy = 1. Reset mid-sweep aborts immediately; no clr_done pulse.
- Reads: combinational, zero latency; rd_data[k] = regs[rd_addr[k]]. Address >= DEPTH (non-power-of-2 DEPTH) reads 0.
- Writes: accepted at rising edge when wr_en and wr_rdy; visible on rd_data in the next cycle. Address >= DEPTH ignored.
- Both ports enabled, different addresses: both written. Same address: port 1 data written, port 0 dropped.
- ZERO_REG=1: writes to address 0 ignored; reads of address 0 return 0 regardless of storage.
- Clear FSM states IDLE, SWEEP, DONE:
  - IDLE: clr_req=1 at edge -> SWEEP, clr_ptr=0. Writes in the same cycle as clr_req are still accepted (wr_rdy still 1).
  - SWEEP: clr_busy=1, wr_rdy=0. Each edge: regs[clr_ptr] <= 0, clr_ptr++. After writing clr_ptr = DEPTH-1 -> DONE. Sweep lasts exactly DEPTH cycles.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle, wr_rdy=1. Next edge -> IDLE.
  - clr_req in SWEEP or DONE: ignored (not queued).
  - Writes presented while wr_rdy=0: dropped silently; the driver must hold them.
  - Reads during SWEEP: return current storage (mix of cleared and uncleared registers).

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-to-read forwarding. If a write is accepted this cycle to the address on rd_addr[k], rd_data[k] returns that write data combinationally in the same cycle. Port 1 data is forwarded over port 0 on an address match. Nothing is forwarded to address 0 when ZERO_REG=1, or when wr_rdy=0.
- Not defined: reads return the pre-edge stored value; new data appears the cycle after the write.

Test Plan:
1. Reset, then read all 8 addresses -> every rd_data = 0x00; clr_busy=0, clr_done=0, wr_rdy=1.
2. Write port0 addr3=0xA5, then read port0/port1 addr3 next cycle -> 0xA5 on both. Same-cycle read -> 0xA5 with RF_BYPASS_EN, 0x00 without.
3. wr_en0 and wr_en1 both to addr5, data 0x11 and 0x22 -> addr5 = 0x22. Port0 addr2=0x33 with port1 addr6=0x44 -> both written.
4. Fill regs with 0x10..0x17, pulse clr_req -> clr_busy high 8 cycles; reg n = 0 from cycle n+1; clr_done pulses 1 cycle; then all reads 0. Write 0xFF during busy -> dropped; clr_req during busy -> no second sweep.
5. Start sweep, assert reset after 3 cycles -> all regs 0 immediately, FSM IDLE, no clr_done pulse.
6. ZERO_REG=1: write addr0=0x7E -> read addr0 = 0x00; with RF_BYPASS_EN, same-cycle read of addr0 also 0x00.

Source files
------------

// File: rtl/reg_file_param.sv
// Parameterised multi-port register file: NUM_RD combinational read ports, two prioritised write ports,
// a DEPTH-cycle sweep-clear sequencer, and an optional hard-wired zero register. Define RF_BYPASS_EN for write-to-read forwarding.

module rf_rd_port #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
  output logic [DATA_W-1:0]            data_o
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic in_range;
  assign in_range = {1'b0, addr_i} < DEPTH_W;

  always_comb begin
    data_o = '0;
    if (in_range && !(ZERO_REG != 0 && addr_i == '0))
      data_o = regs_i[addr_i];
  end
endmodule

module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  input  logic                       wr_en0_i,
  input  logic [ADDR_W-1:0]          wr_addr0_i,
  input  logic [DATA_W-1:0]          wr_data0_i,
  input  logic                       wr_en1_i,
  input  logic [ADDR_W-1:0]          wr_addr1_i,
  input  logic [DATA_W-1:0]          wr_data1_i,
  output logic                       wr_rdy_o,
  input  logic                       clr_req_i,
  output logic                       clr_busy_o,
  output logic                       clr_done_o
);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_w;
  logic                        we0, we1;

  assign wr_rdy_o   = (state_q != SWEEP);
  assign clr_busy_o = (state_q == SWEEP);
  assign clr_done_o = (state_q == DONE);

  // Accepted writes exclude out-of-range and (optionally) zero-register targets,
  // so the same qualifiers gate storage and forwarding.
  assign we0 = wr_en0_i && wr_rdy_o && ({1'b0, wr_addr0_i} < DEPTH_W) &&
               !(ZERO_REG != 0 && wr_addr0_i == '0);
  assign we1 = wr_en1_i && wr_rdy_o && ({1'b0, wr_addr1_i} < DEPTH_W) &&
               !(ZERO_REG != 0 && wr_addr1_i == '0);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: if (clr_req_i) begin
        state_d   = SWEEP;
        clr_ptr_d = '0;
      end
      SWEEP: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = DONE;
          clr_ptr_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port 1 is applied last so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (state_q == SWEEP) begin
      regs_d[clr_ptr_q] = '0;
    end else begin
      if (we0) regs_d[wr_addr0_i] = wr_data0_i;
      if (we1) regs_d[wr_addr1_i] = wr_data1_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

    rf_rd_port #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr_i(ra),
      .regs_i(regs_q),
      .data_o(stored)
    );

`ifdef RF_BYPASS_EN
    assign rd_w[k] = (we1 && wr_addr1_i == ra) ? wr_data1_i :
                     (we0 && wr_addr0_i == ra) ? wr_data0_i : stored;
`else
    assign rd_w[k] = stored;
`endif
  end

  assign rd_data_o = rd_w;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a default instance and a ZERO_REG=1 instance share stimulus,
// checked against an array-based model of storage and the clear sequence.

module tb_reg_file_param;
  localparam int DW = 8, DEPTH = 8, AW = 3, NR = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_z;
  logic wr_en0, wr_en1, clr_req;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic wr_rdy, clr_busy, clr_done, wr_rdy_z, clr_busy_z, clr_done_z;

  int checks = 0, errors = 0;

  // Model: storage per instance, and sweep position (-1 idle, 0..DEPTH-1 next reg to clear, DEPTH = done cycle)
  logic [DW-1:0] m [2][DEPTH];
  int sweep_pos = -1;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_en0_i(wr_en0), .wr_addr0_i(wr_addr0), .wr_data0_i(wr_data0),
    .wr_en1_i(wr_en1), .wr_addr1_i(wr_addr1), .wr_data1_i(wr_data1),
    .wr_rdy_o(wr_rdy), .clr_req_i(clr_req), .clr_busy_o(clr_busy), .clr_done_o(clr_done));

  reg_file_param #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z),
    .wr_en0_i(wr_en0), .wr_addr0_i(wr_addr0), .wr_data0_i(wr_data0),
    .wr_en1_i(wr_en1), .wr_addr1_i(wr_addr1), .wr_data1_i(wr_data1),
    .wr_rdy_o(wr_rdy_z), .clr_req_i(clr_req), .clr_busy_o(clr_busy_z), .clr_done_o(clr_done_z));

  function automatic bit m_busy();
    return sweep_pos >= 0 && sweep_pos < DEPTH;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int z, logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (z == 1 && a == 0) return '0;
    v = m[z][a];
`ifdef RF_BYPASS_EN
    if (!m_busy() && wr_en1 && wr_addr1 == a) v = wr_data1;
    else if (!m_busy() && wr_en0 && wr_addr0 == a) v = wr_data0;
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < DEPTH; i++) m[z][i] = '0;
    sweep_pos = -1;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
      return;
    end
    if (!m_busy())
      for (int z = 0; z < 2; z++) begin
        if (wr_en0 && !(z == 1 && wr_addr0 == 0)) m[z][wr_addr0] = wr_data0;
        if (wr_en1 && !(z == 1 && wr_addr1 == 0)) m[z][wr_addr1] = wr_data1;
      end
    if (m_busy()) begin
      for (int z = 0; z < 2; z++) m[z][sweep_pos] = '0;
      sweep_pos++;
    end else if (sweep_pos == DEPTH) sweep_pos = -1;
    else if (clr_req) sweep_pos = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en0 = 0; wr_en1 = 0; clr_req = 0;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] got;
    reset = 1; idle_inputs(); rd_addr = '0;
    tick(); tick();
    reset = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(DEPTH-1-a)};
      #1;
      for (int k = 0; k < NR; k++) begin
        got = rd_data[k*DW +: DW];
        checks++;
        if (got !== 8'h00) begin
          errors++; $display("FAIL reset_read a=%0d port=%0d got=%h exp=00", a, k, got);
        end
      end
    end
    checks++;
    if ({wr_rdy, clr_busy, clr_done} !== 3'b100) begin
      errors++; $display("FAIL reset_status got rdy/busy/done=%b exp=100", {wr_rdy, clr_busy, clr_done});
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] got;
    wr_en0 = 1; wr_addr0 = 3; wr_data0 = 8'hA5; rd_addr = {3'd3, 3'd3};
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      got = rd_data[k*DW +: DW];
      checks++;
`ifdef RF_BYPASS_EN
      if (got !== 8'hA5) begin errors++; $display("FAIL same_cycle_read port=%0d got=%h exp=a5", k, got); end
`else
      if (got !== 8'h00) begin errors++; $display("FAIL same_cycle_read port=%0d got=%h exp=00", k, got); end
`endif
    end
    tick();
    wr_en0 = 0;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      got = rd_data[k*DW +: DW];
      checks++;
      if (got !== 8'hA5) begin errors++; $display("FAIL next_cycle_read port=%0d got=%h exp=a5", k, got); end
    end
    tick();
  endtask

  task automatic test_dual_write();
    logic [DW-1:0] got;
    wr_en0 = 1; wr_addr0 = 5; wr_data0 = 8'h11;
    wr_en1 = 1; wr_addr1 = 5; wr_data1 = 8'h22;
    tick();
    wr_addr0 = 2; wr_data0 = 8'h33; wr_addr1 = 6; wr_data1 = 8'h44;
    tick();
    idle_inputs();
    rd_addr = {3'd5, 3'd2};
    @(negedge clk);
    got = rd_data[DW +: DW]; checks++;
    if (got !== 8'h22) begin errors++; $display("FAIL collide_addr5 got=%h exp=22", got); end
    got = rd_data[0 +: DW]; checks++;
    if (got !== 8'h33) begin errors++; $display("FAIL dual_addr2 got=%h exp=33", got); end
    rd_addr = {3'd6, 3'd6};
    #1;
    got = rd_data[0 +: DW]; checks++;
    if (got !== 8'h44) begin errors++; $display("FAIL dual_addr6 got=%h exp=44", got); end
    tick();
  endtask

  task automatic test_random();
    logic [NR*DW-1:0] bus;
    logic [DW-1:0] got, exp;
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      wr_en0 = 1'($urandom); wr_addr0 = AW'($urandom); wr_data0 = DW'($urandom);
      wr_en1 = 1'($urandom); wr_addr1 = AW'($urandom); wr_data1 = DW'($urandom);
      if ($urandom_range(0, 3) == 0) wr_addr1 = wr_addr0;
      clr_req = ($urandom_range(0, 39) == 0);
      rd_addr = (NR*AW)'($urandom);
      @(negedge clk);
      for (int z = 0; z < 2; z++) begin
        bus = z ? rd_data_z : rd_data;
        for (int k = 0; k < NR; k++) begin
          a = rd_addr[k*AW +: AW];
          got = bus[k*DW +: DW];
          exp = exp_rd(z, a);
          checks++;
          if (got !== exp) begin
            errors++; $display("FAIL random_read cyc=%0d inst=%0d port=%0d addr=%0d got=%h exp=%h", c, z, k, a, got, exp);
          end
        end
      end
      checks++;
      if ({wr_rdy, clr_busy, clr_done, wr_rdy_z, clr_busy_z, clr_done_z} !==
          {2{!m_busy(), m_busy(), sweep_pos == DEPTH}}) begin
        errors++; $display("FAIL random_status cyc=%0d got=%b%b%b/%b%b%b exp busy=%0b done=%0b", c,
                           wr_rdy, clr_busy, clr_done, wr_rdy_z, clr_busy_z, clr_done_z, m_busy(), sweep_pos == DEPTH);
      end
      tick();
    end
    idle_inputs();
    while (sweep_pos != -1) tick();
  endtask

  task automatic test_sweep();
    logic [DW-1:0] got, exp;
    int busy_cnt = 0, done_cnt = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      wr_en0 = 1; wr_addr0 = AW'(i);   wr_data0 = DW'(8'h10 + i);
      wr_en1 = 1; wr_addr1 = AW'(i+1); wr_data1 = DW'(8'h11 + i);
      tick();
    end
    idle_inputs();
    clr_req = 1;
    tick();
    for (int c = 0; c < DEPTH + 4; c++) begin
      // Hold a write and clr_req while busy: both must be ignored
      wr_en0 = m_busy(); wr_addr0 = AW'($urandom); wr_data0 = 8'hFF;
      clr_req = m_busy();
      rd_addr = (NR*AW)'($urandom);
      @(negedge clk);
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      for (int k = 0; k < NR; k++) begin
        got = rd_data[k*DW +: DW];
        exp = exp_rd(0, rd_addr[k*AW +: AW]);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sweep_read cyc=%0d port=%0d got=%h exp=%h", c, k, got, exp); end
      end
      checks++;
      if (wr_rdy !== !m_busy()) begin errors++; $display("FAIL sweep_wr_rdy cyc=%0d got=%b exp=%b", c, wr_rdy, !m_busy()); end
      tick();
    end
    idle_inputs();
    checks++;
    if (busy_cnt != DEPTH) begin errors++; $display("FAIL sweep_busy_cycles got=%0d exp=%0d", busy_cnt, DEPTH); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL sweep_done_pulses got=%0d exp=1", done_cnt); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      got = rd_data[0 +: DW];
      checks++;
      if (got !== 8'h00) begin errors++; $display("FAIL sweep_all_zero a=%0d got=%h exp=00", a, got); end
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    logic [DW-1:0] got;
    int done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en0 = 1; wr_addr0 = AW'(i); wr_data0 = DW'($urandom_range(1, 255));
      tick();
    end
    idle_inputs();
    clr_req = 1; tick(); clr_req = 0;
    tick(); tick(); tick();
    #2 reset = 1;
    model_clear();
    #1;
    checks++;
    if ({wr_rdy, clr_busy, clr_done} !== 3'b100) begin
      errors++; $display("FAIL abort_status got rdy/busy/done=%b exp=100", {wr_rdy, clr_busy, clr_done});
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #0.1;
      got = rd_data[DW +: DW];
      checks++;
      if (got !== 8'h00) begin errors++; $display("FAIL abort_read a=%0d got=%h exp=00", a, got); end
    end
    tick();
    reset = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      @(negedge clk);
      done_cnt += int'(clr_done) + int'(clr_busy);
      tick();
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d busy/done cycles exp=0", done_cnt); end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] got, exp;
    wr_en0 = 1; wr_addr0 = 0; wr_data0 = 8'h7E; rd_addr = {3'd0, 3'd0};
    @(negedge clk);
    got = rd_data_z[0 +: DW]; checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL zero_same_cycle got=%h exp=00", got); end
    got = rd_data[0 +: DW]; exp = exp_rd(0, 3'd0); checks++;
    if (got !== exp) begin errors++; $display("FAIL plain_addr0_same_cycle got=%h exp=%h", got, exp); end
    tick();
    wr_en0 = 0; wr_en1 = 1; wr_addr1 = 0; wr_data1 = 8'h5A;
    tick();
    idle_inputs();
    @(negedge clk);
    got = rd_data_z[DW +: DW]; checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL zero_after_write got=%h exp=00", got); end
    got = rd_data[DW +: DW]; checks++;
    if (got !== 8'h5A) begin errors++; $display("FAIL plain_addr0_after_write got=%h exp=5a", got); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_write();
    test_sweep();
    test_reset_mid_sweep();
    test_zero_reg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
